// File: rtl/alarm_ctrl.sv
// Alarm controller: BCD alarm-time editor, arm/ring/timeout state machine and an
// optional dismiss mini-game that is compiled in when ALARM_GAME_EN is defined.
module alarm_ctrl #(
   parameter int unsigned RING_SECONDS = 30,
   parameter int unsigned GAME_HITS    = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tick,
   input  logic [15:0] current_time,
   input  logic        alarm_en,
   input  logic        set_mode,
   input  logic        btn_sel,
   input  logic        btn_inc,
   input  logic        btn_confirm,
   input  logic [9:0]  game_sw,
   output logic [2:0]  alarm_state,
   output logic [15:0] alarm_time,
   output logic [3:0]  which_seg_on2,
   output logic [9:0]  mini_game_led,
   output logic [15:0] num4
);

   typedef enum logic [2:0] {
      ST_OFF   = 3'b000,
      ST_ARMED = 3'b001,
      ST_RING  = 3'b010,
      ST_GAME  = 3'b100
   } state_e;

   localparam logic [7:0] RING_LIMIT = 8'(RING_SECONDS);
   localparam logic [3:0] HIT_LIMIT  = 4'(GAME_HITS);

   function automatic logic [3:0] digit_inc(input logic [3:0] d, input logic [3:0] max_d);
      return (d >= max_d) ? 4'd0 : d + 4'd1;
   endfunction

   // Increment only the nibble selected by the one-hot edit marker, never carrying.
   function automatic logic [15:0] time_inc(input logic [15:0] t, input logic [3:0] seg);
      logic [15:0] r;
      r = t;
      case (seg)
         4'b0001: r[7:4]   = digit_inc(t[7:4], 4'd5);
         4'b0010: r[11:8]  = digit_inc(t[11:8], 4'd9);
         4'b0100: r[15:12] = digit_inc(t[15:12], 4'd5);
         4'b1000: r[3:0]   = digit_inc(t[3:0], 4'd9);
         default: r = t;
      endcase
      return r;
   endfunction

   state_e      state_q, state_d;
   logic [15:0] time_q, time_d;
   logic [3:0]  seg_q, seg_d;
   logic [7:0]  ring_q, ring_d;
   logic        match_q;
   logic        match_s;
   logic        match_rise_s;
   logic        leave_ring_s;

   assign match_s      = (current_time == time_q);
   assign match_rise_s = match_s & ~match_q;

`ifdef ALARM_GAME_EN
   function automatic logic [9:0] onehot10(input logic [3:0] idx);
      return 10'd1 << idx;
   endfunction

   // Fold the LFSR into 0..9 and never repeat the target currently shown.
   function automatic logic [3:0] draw_target(input logic [3:0] lfsr, input logic [3:0] cur);
      logic [3:0] t;
      t = (lfsr >= 4'd10) ? lfsr - 4'd10 : lfsr;
      if (t == cur) begin
         t = (t == 4'd9) ? 4'd0 : t + 4'd1;
      end else begin
         t = t;
      end
      return t;
   endfunction

   logic [3:0] lfsr_q, lfsr_d;
   logic [3:0] hits_q, hits_d;
   logic [3:0] target_q, target_d;
   logic [9:0] led_q, led_d;
   logic [9:0] game_sw_q;
   logic [9:0] game_edge_s;

   assign lfsr_d       = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
   assign game_edge_s  = game_sw ^ game_sw_q;
   assign leave_ring_s = btn_confirm | (|game_edge_s);

   assign mini_game_led = led_q;
   assign num4          = {12'h000, hits_q};
`else
   logic unused_s;

   assign unused_s      = ^{game_sw, HIT_LIMIT};
   assign leave_ring_s  = btn_confirm;
   assign mini_game_led = 10'd0;
   assign num4          = 16'h0000;
`endif

   assign alarm_state   = state_q;
   assign alarm_time    = time_q;
   assign which_seg_on2 = seg_q;

   // Alarm-time editor: increment the old digit first, then rotate the marker.
   always_comb begin
      time_d = time_q;
      seg_d  = seg_q;
      if (set_mode && (state_q == ST_OFF || state_q == ST_ARMED)) begin
         if (btn_inc) begin
            time_d = time_inc(time_q, seg_q);
         end else begin
            time_d = time_q;
         end
         if (btn_sel) begin
            seg_d = {seg_q[2:0], seg_q[3]};
         end else begin
            seg_d = seg_q;
         end
      end else begin
         time_d = time_q;
         seg_d  = seg_q;
      end
   end

   // Next-state logic; alarm_en low overrides every state transition.
   always_comb begin
      state_d  = state_q;
      ring_d   = ring_q;
`ifdef ALARM_GAME_EN
      hits_d   = hits_q;
      target_d = target_q;
`endif
      if (!alarm_en) begin
         state_d = ST_OFF;
      end else begin
         case (state_q)
            ST_OFF: begin
               if (set_mode && btn_confirm) begin
                  state_d = ST_ARMED;
               end else begin
                  state_d = ST_OFF;
               end
            end
            ST_ARMED: begin
               if (match_rise_s) begin
                  state_d = ST_RING;
                  ring_d  = 8'd0;
               end else begin
                  state_d = ST_ARMED;
               end
            end
            ST_RING: begin
               if (leave_ring_s) begin
`ifdef ALARM_GAME_EN
                  state_d  = ST_GAME;
                  hits_d   = 4'd0;
                  target_d = draw_target(lfsr_q, target_q);
`else
                  state_d  = ST_ARMED;
`endif
               end else if (tick) begin
                  if (ring_q + 8'd1 == RING_LIMIT) begin
                     state_d = ST_ARMED;
                  end else begin
                     ring_d = ring_q + 8'd1;
                  end
               end else begin
                  state_d = ST_RING;
               end
            end
`ifdef ALARM_GAME_EN
            ST_GAME: begin
               if (game_edge_s == 10'd0) begin
                  state_d = ST_GAME;
               end else if (game_edge_s == onehot10(target_q)) begin
                  hits_d = hits_q + 4'd1;
                  if (hits_q + 4'd1 == HIT_LIMIT) begin
                     state_d = ST_ARMED;
                  end else begin
                     target_d = draw_target(lfsr_q, target_q);
                  end
               end else begin
                  hits_d = 4'd0;
               end
            end
`endif
            default: state_d = ST_OFF;
         endcase
      end
`ifdef ALARM_GAME_EN
      led_d = (state_d == ST_GAME) ? onehot10(target_d) : 10'd0;
`endif
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_OFF;
         time_q    <= 16'h0000;
         seg_q     <= 4'b0001;
         ring_q    <= 8'd0;
         match_q   <= 1'b0;
`ifdef ALARM_GAME_EN
         lfsr_q    <= 4'b1001;
         hits_q    <= 4'd0;
         target_q  <= 4'd0;
         led_q     <= 10'd0;
         game_sw_q <= game_sw;
`endif
      end else begin
         state_q   <= state_d;
         time_q    <= time_d;
         seg_q     <= seg_d;
         ring_q    <= ring_d;
         match_q   <= match_s;
`ifdef ALARM_GAME_EN
         lfsr_q    <= lfsr_d;
         hits_q    <= hits_d;
         target_q  <= target_d;
         led_q     <= led_d;
         game_sw_q <= game_sw;
`endif
      end
   end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed table-driven bench for alarm_ctrl plus hand sequences for ring timeout,
// retrigger, reset-abandon and (with ALARM_GAME_EN) the dismiss game.
module tb_alarm_ctrl;

   logic        clk = 1'b0;
   logic        reset, tick, alarm_en, set_mode, btn_sel, btn_inc, btn_confirm;
   logic [15:0] current_time;
   logic [9:0]  game_sw;
   logic [2:0]  alarm_state;
   logic [15:0] alarm_time;
   logic [3:0]  which_seg_on2;
   logic [9:0]  mini_game_led;
   logic [15:0] num4;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alarm_ctrl #(.RING_SECONDS(30), .GAME_HITS(5)) dut (
      .clk(clk), .reset(reset), .tick(tick), .current_time(current_time),
      .alarm_en(alarm_en), .set_mode(set_mode), .btn_sel(btn_sel), .btn_inc(btn_inc),
      .btn_confirm(btn_confirm), .game_sw(game_sw), .alarm_state(alarm_state),
      .alarm_time(alarm_time), .which_seg_on2(which_seg_on2),
      .mini_game_led(mini_game_led), .num4(num4)
   );

   typedef struct packed {
      logic        rst;
      logic        sm;
      logic        en;
      logic        sel;
      logic        inc;
      logic        conf;
      logic        tk;
      logic [15:0] ct;
      logic [2:0]  st;
      logic [15:0] tm;
      logic [3:0]  seg;
   } vec_t;

   function automatic vec_t mk(input logic rst, input logic sm, input logic en,
                               input logic sel, input logic inc, input logic conf,
                               input logic tk, input logic [15:0] ct, input logic [2:0] st,
                               input logic [15:0] tm, input logic [3:0] seg);
      vec_t v;
      v.rst = rst; v.sm = sm; v.en = en; v.sel = sel; v.inc = inc; v.conf = conf;
      v.tk = tk; v.ct = ct; v.st = st; v.tm = tm; v.seg = seg;
      return v;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic sm, input logic en, input logic s,
                       input logic i, input logic c, input logic t, input logic [15:0] ct,
                       input logic [9:0] gs);
      @(negedge clk);
      reset = r; set_mode = sm; alarm_en = en; btn_sel = s; btn_inc = i;
      btn_confirm = c; tick = t; current_time = ct; game_sw = gs;
      @(posedge clk);
      #1;
   endtask

   function automatic int led_index(input logic [9:0] led);
      int idx;
      idx = 0;
      for (int b = 0; b < 10; b++) begin
         if (led[b]) idx = b;
      end
      return idx;
   endfunction

   vec_t vecs[35];
   logic [9:0] g;
   logic [9:0] saved_led;
   int idx;

   initial begin
      vecs[0]  = mk(0,1,1,1,0,0,0,16'h0000,3'b000,16'h0000,4'b0010);
      vecs[1]  = mk(0,1,1,0,1,0,0,16'h0000,3'b000,16'h0100,4'b0010);
      vecs[2]  = mk(0,1,1,0,1,0,0,16'h0000,3'b000,16'h0200,4'b0010);
      vecs[3]  = mk(0,1,1,0,1,0,0,16'h0000,3'b000,16'h0300,4'b0010);
      vecs[4]  = mk(0,1,1,1,0,0,0,16'h0000,3'b000,16'h0300,4'b0100);
      vecs[5]  = mk(0,1,1,0,1,0,0,16'h0000,3'b000,16'h1300,4'b0100);
      vecs[6]  = mk(0,1,1,0,1,0,0,16'h0000,3'b000,16'h2300,4'b0100);
      vecs[7]  = mk(0,1,1,0,1,0,0,16'h0000,3'b000,16'h3300,4'b0100);
      vecs[8]  = mk(0,1,1,0,1,0,0,16'h0000,3'b000,16'h4300,4'b0100);
      vecs[9]  = mk(0,1,1,0,1,0,0,16'h0000,3'b000,16'h5300,4'b0100);
      vecs[10] = mk(0,1,1,0,1,0,0,16'h0000,3'b000,16'h0300,4'b0100);
      vecs[11] = mk(0,1,1,1,1,0,0,16'h0000,3'b000,16'h1300,4'b1000);
      vecs[12] = mk(0,1,1,0,1,0,0,16'h0000,3'b000,16'h1301,4'b1000);
      vecs[13] = mk(0,1,1,1,0,0,0,16'h0000,3'b000,16'h1301,4'b0001);
      vecs[14] = mk(0,1,1,0,1,0,0,16'h0000,3'b000,16'h1311,4'b0001);
      vecs[15] = mk(0,0,1,0,1,0,0,16'h0000,3'b000,16'h1311,4'b0001);
      vecs[16] = mk(0,0,1,1,0,0,0,16'h0000,3'b000,16'h1311,4'b0001);
      vecs[17] = mk(0,1,0,0,0,1,0,16'h0000,3'b000,16'h1311,4'b0001);
      vecs[18] = mk(0,1,1,0,0,1,0,16'h0000,3'b001,16'h1311,4'b0001);
      vecs[19] = mk(0,1,1,1,0,0,0,16'h0000,3'b001,16'h1311,4'b0010);
      vecs[20] = mk(0,1,0,0,0,0,0,16'h0000,3'b000,16'h1311,4'b0010);
      vecs[21] = mk(1,1,1,0,0,0,0,16'h0000,3'b000,16'h0000,4'b0001);
      vecs[22] = mk(0,1,1,1,0,0,0,16'h0000,3'b000,16'h0000,4'b0010);
      vecs[23] = mk(0,1,1,0,1,0,0,16'h0000,3'b000,16'h0100,4'b0010);
      vecs[24] = mk(0,1,1,1,0,0,0,16'h0000,3'b000,16'h0100,4'b0100);
      vecs[25] = mk(0,1,1,1,0,0,0,16'h0000,3'b000,16'h0100,4'b1000);
      vecs[26] = mk(0,1,1,0,1,0,0,16'h0000,3'b000,16'h0101,4'b1000);
      vecs[27] = mk(0,1,1,0,1,0,0,16'h0000,3'b000,16'h0102,4'b1000);
      vecs[28] = mk(0,1,1,0,1,0,0,16'h0000,3'b000,16'h0103,4'b1000);
      vecs[29] = mk(0,1,1,0,1,0,0,16'h0000,3'b000,16'h0104,4'b1000);
      vecs[30] = mk(0,1,1,0,1,0,0,16'h0000,3'b000,16'h0105,4'b1000);
      vecs[31] = mk(0,1,1,0,0,1,0,16'h0104,3'b001,16'h0105,4'b1000);
      vecs[32] = mk(0,0,1,0,0,0,0,16'h0104,3'b001,16'h0105,4'b1000);
      vecs[33] = mk(0,0,1,0,0,0,1,16'h0105,3'b010,16'h0105,4'b1000);
      vecs[34] = mk(0,0,1,0,0,0,0,16'h0105,3'b010,16'h0105,4'b1000);

      g = 10'd0;
      step(1,0,1,0,0,0,0,16'h0000,g);
      step(1,0,1,0,0,0,0,16'h0000,g);
      check("rst_state", {13'd0, alarm_state}, 16'h0000);
      check("rst_time", alarm_time, 16'h0000);
      check("rst_seg", {12'd0, which_seg_on2}, 16'h0001);
      check("rst_led", {6'd0, mini_game_led}, 16'h0000);
      check("rst_num4", num4, 16'h0000);

      for (int i = 0; i < 35; i++) begin
         step(vecs[i].rst, vecs[i].sm, vecs[i].en, vecs[i].sel, vecs[i].inc,
              vecs[i].conf, vecs[i].tk, vecs[i].ct, g);
         check($sformatf("v%0d_state", i), {13'd0, alarm_state}, {13'd0, vecs[i].st});
         check($sformatf("v%0d_time", i), alarm_time, vecs[i].tm);
         check($sformatf("v%0d_seg", i), {12'd0, which_seg_on2}, {12'd0, vecs[i].seg});
      end

      for (int k = 1; k <= 30; k++) begin
         step(0,0,1,0,0,0,1,16'h0105,g);
         if (k == 29) check("ring_29_ticks", {13'd0, alarm_state}, 16'h0002);
         if (k == 30) check("ring_timeout", {13'd0, alarm_state}, 16'h0001);
         step(0,0,1,0,0,0,0,16'h0105,g);
      end
      for (int k = 0; k < 3; k++) begin
         step(0,0,1,0,0,0,1,16'h0105,g);
         check($sformatf("held_match_%0d", k), {13'd0, alarm_state}, 16'h0001);
      end

      step(0,0,1,0,0,0,1,16'h0106,g);
      check("match_fall", {13'd0, alarm_state}, 16'h0001);
      step(0,0,1,0,0,0,1,16'h0105,g);
      check("retrigger", {13'd0, alarm_state}, 16'h0002);
      step(0,0,1,0,0,1,0,16'h0105,g);
`ifdef ALARM_GAME_EN
      check("ring_confirm_game", {13'd0, alarm_state}, 16'h0004);
      check("game_entry_num4", num4, 16'h0000);
      check("game_led_onehot", {15'd0, $onehot(mini_game_led)}, 16'h0001);
      for (int k = 0; k < 5; k++) begin
         idx = led_index(mini_game_led);
         g[idx] = ~g[idx];
         step(0,0,1,0,0,0,0,16'h0105,g);
         check($sformatf("hit%0d_num4", k + 1), num4, 16'(k + 1));
         check($sformatf("hit%0d_state", k + 1), {13'd0, alarm_state},
               (k == 4) ? 16'h0001 : 16'h0004);
      end
      check("win_led", {6'd0, mini_game_led}, 16'h0000);
      step(0,0,1,0,0,0,0,16'h0106,g);
      step(0,0,1,0,0,0,0,16'h0105,g);
      check("game_ring2", {13'd0, alarm_state}, 16'h0002);
      check("win_num4_hold", num4, 16'h0005);
      g[9] = ~g[9];
      step(0,0,1,0,0,0,0,16'h0105,g);
      check("sw_enter_game", {13'd0, alarm_state}, 16'h0004);
      check("sw_enter_num4", num4, 16'h0000);
      for (int k = 0; k < 3; k++) begin
         idx = led_index(mini_game_led);
         g[idx] = ~g[idx];
         step(0,0,1,0,0,0,0,16'h0105,g);
      end
      check("three_hits", num4, 16'h0003);
      saved_led = mini_game_led;
      idx = (led_index(mini_game_led) == 0) ? 1 : 0;
      g[idx] = ~g[idx];
      step(0,0,1,0,0,0,0,16'h0105,g);
      check("wrong_num4", num4, 16'h0000);
      check("wrong_state", {13'd0, alarm_state}, 16'h0004);
      check("wrong_led_kept", {6'd0, mini_game_led}, {6'd0, saved_led});
      step(0,0,0,0,0,0,0,16'h0105,g);
      check("game_disable_state", {13'd0, alarm_state}, 16'h0000);
      check("game_disable_led", {6'd0, mini_game_led}, 16'h0000);
`else
      check("ring_confirm_armed", {13'd0, alarm_state}, 16'h0001);
      step(0,0,1,0,0,0,0,16'h0106,g);
      step(0,0,1,0,0,0,0,16'h0105,g);
      check("ring_again", {13'd0, alarm_state}, 16'h0002);
      g = 10'h001;
      step(0,0,1,0,0,0,0,16'h0105,g);
      check("sw_ignored_state", {13'd0, alarm_state}, 16'h0002);
      check("sw_ignored_led", {6'd0, mini_game_led}, 16'h0000);
      check("sw_ignored_num4", num4, 16'h0000);
      step(0,0,0,0,0,0,0,16'h0105,g);
      check("ring_disable_state", {13'd0, alarm_state}, 16'h0000);
`endif
      check("disable_keeps_time", alarm_time, 16'h0105);

      step(0,1,1,0,0,1,0,16'h0106,g);
      check("rearm", {13'd0, alarm_state}, 16'h0001);
      step(0,0,1,0,0,0,0,16'h0105,g);
      check("ring_before_rst", {13'd0, alarm_state}, 16'h0002);
      step(1,0,1,0,0,0,0,16'h0105,g);
      check("rst_mid_ring", {13'd0, alarm_state}, 16'h0000);
      step(0,0,1,0,0,0,0,16'h0106,g);
      step(0,0,1,0,0,0,1,16'h0105,g);
      check("no_ring_after_rst", {13'd0, alarm_state}, 16'h0000);
      check("time_after_rst", alarm_time, 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
